// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC select and next-PC predictor with an optional return-address stack.
// Define FETCH_RAS_EN to build in the RAS; otherwise rets predict their fall-through.
module fetch_pc_unit #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              F_stall,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic [3:0]        M_icode,
    input  logic              M_Cnd,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [3:0]        W_icode,
    input  logic [ADDR_W-1:0] W_valM,
    input  logic              W_ras_used,
    input  logic [ADDR_W-1:0] W_ras_pred,
    output logic [ADDR_W-1:0] f_pc,
    output logic [ADDR_W-1:0] F_predPC,
    output logic              f_ras_used,
    output logic [ADDR_W-1:0] f_ras_pred
);

    localparam logic [3:0] I_JXX  = 4'd7;
    localparam logic [3:0] I_CALL = 4'd8;
    localparam logic [3:0] I_RET  = 4'd9;

    logic [ADDR_W-1:0] pred_pc_q;
    logic [ADDR_W-1:0] pred_pc_d;
    logic [ADDR_W-1:0] next_pc;
    logic              m_mispredict;
    logic              ret_redirect;
    logic              redirect;
    logic              ras_hit;
    logic [ADDR_W-1:0] ras_top;

    always_comb begin
        m_mispredict = (M_icode == I_JXX) && !M_Cnd;
`ifdef FETCH_RAS_EN
        // A ret whose RAS guess matched the real return address needs no redirect.
        ret_redirect = (W_icode == I_RET) && !(W_ras_used && (W_valM == W_ras_pred));
`else
        ret_redirect = (W_icode == I_RET);
`endif
        redirect = m_mispredict || ret_redirect;
        if (m_mispredict) begin
            f_pc = M_valA;
        end else if (ret_redirect) begin
            f_pc = W_valM;
        end else begin
            f_pc = pred_pc_q;
        end
    end

`ifdef FETCH_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_eff;

    // ptr_q is the next free slot; the top of stack sits one below it.
    always_comb begin
        cnt_eff = (redirect && !F_stall) ? '0 : cnt_q;
        top_idx = ptr_q - PTR_W'(1);
        ras_top = ras_q[top_idx];
        ras_hit = (f_icode == I_RET) && (cnt_eff != '0);
        ras_d   = ras_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (!F_stall) begin
            cnt_d = cnt_eff;
            if (f_icode == I_CALL) begin
                // When full the free slot is the oldest entry, so it is overwritten.
                ras_d[ptr_q] = f_valP;
                ptr_d        = ptr_q + PTR_W'(1);
                if (cnt_eff != CNT_W'(RAS_DEPTH)) begin
                    cnt_d = cnt_eff + CNT_W'(1);
                end
            end else if (ras_hit) begin
                ptr_d = top_idx;
                cnt_d = cnt_eff - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ras_q <= ras_d;
        end
    end

    assign f_ras_used = ras_hit;
    assign f_ras_pred = ras_hit ? ras_top : '0;
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = ^{W_ras_used, W_ras_pred, redirect};
    assign ras_hit    = 1'b0;
    assign ras_top    = '0;
    assign f_ras_used = 1'b0;
    assign f_ras_pred = '0;
`endif

    always_comb begin
        case (f_icode)
            I_JXX, I_CALL: next_pc = f_valC;
            I_RET:         next_pc = ras_hit ? ras_top : f_valP;
            default:       next_pc = f_valP;
        endcase
        pred_pc_d = F_stall ? pred_pc_q : next_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc_q <= RESET_PC;
        end else begin
            pred_pc_q <= pred_pc_d;
        end
    end

    assign F_predPC = pred_pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus random traffic
// against a queue-based model of the predictor and return-address stack.
module tb_fetch_pc_unit;

    localparam int AW = 64;
    localparam int DEPTH = 4;
`ifdef FETCH_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          F_stall = 1'b0;
    logic [3:0]    f_icode = '0;
    logic [AW-1:0] f_valC = '0;
    logic [AW-1:0] f_valP = '0;
    logic [3:0]    M_icode = '0;
    logic          M_Cnd = 1'b0;
    logic [AW-1:0] M_valA = '0;
    logic [3:0]    W_icode = '0;
    logic [AW-1:0] W_valM = '0;
    logic          W_ras_used = 1'b0;
    logic [AW-1:0] W_ras_pred = '0;
    logic [AW-1:0] f_pc;
    logic [AW-1:0] F_predPC;
    logic          f_ras_used;
    logic [AW-1:0] f_ras_pred;

    fetch_pc_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n), .F_stall(F_stall),
        .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM), .W_ras_used(W_ras_used), .W_ras_pred(W_ras_pred),
        .f_pc(f_pc), .F_predPC(F_predPC), .f_ras_used(f_ras_used), .f_ras_pred(f_ras_pred)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: predicted PC plus a stack kept as a queue (back = top).
    logic [AW-1:0] exp_pred = '0;
    logic [AW-1:0] stk [$];
    logic [AW-1:0] e_fpc, e_rpred, e_next;
    logic          e_used, e_flush;

    task automatic model_eval();
        bit mis, rr;
        mis = (M_icode == 4'd7) && !M_Cnd;
        rr  = (W_icode == 4'd9) && !(RAS_ON && W_ras_used && (W_valM == W_ras_pred));
        e_fpc   = mis ? M_valA : (rr ? W_valM : exp_pred);
        e_flush = (mis || rr) && !F_stall;
        e_used  = RAS_ON && (f_icode == 4'd9) && (stk.size() > 0) && !e_flush;
        e_rpred = e_used ? stk[$] : '0;
        if (f_icode == 4'd7 || f_icode == 4'd8) e_next = f_valC;
        else if (e_used)                        e_next = e_rpred;
        else                                    e_next = f_valP;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (!F_stall) begin
            exp_pred = e_next;
            if (e_flush) stk.delete();
            if (f_icode == 4'd8) begin
                stk.push_back(f_valP);
                if (stk.size() > DEPTH) void'(stk.pop_front());
            end else if (e_used) begin
                void'(stk.pop_back());
            end
        end
        #1;
    endtask

    task automatic idle();
        F_stall = 0; f_icode = 0; f_valC = '0; f_valP = '0;
        M_icode = 0; M_Cnd = 0; M_valA = '0;
        W_icode = 0; W_valM = '0; W_ras_used = 0; W_ras_pred = '0;
    endtask

    task automatic flush_ras();
        idle();
        M_icode = 4'd7; M_valA = 64'h800;
        tick();
        idle();
    endtask

    task automatic set_f(input logic [3:0] ic, input logic [AW-1:0] vc, input logic [AW-1:0] vp);
        f_icode = ic; f_valC = vc; f_valP = vp;
    endtask

    task automatic test_reset();
        idle();
        set_f(4'd0, '0, 64'h1);
        @(negedge clk);
        n_checks++;
        if (F_predPC !== 64'h0) begin n_fail++; $display("FAIL reset_predpc got %h want %h", F_predPC, 64'h0); end
        rst_n = 1'b1;
        exp_pred = '0; stk.delete();
        #1;
        n_checks++;
        if (f_pc !== 64'h0) begin n_fail++; $display("FAIL reset_fpc got %h want %h", f_pc, 64'h0); end
        tick();
        n_checks++;
        if (F_predPC !== 64'h1) begin n_fail++; $display("FAIL reset_first_pred got %h want %h", F_predPC, 64'h1); end
    endtask

    task automatic test_jxx_mispredict();
        flush_ras();
        set_f(4'd8, 64'h90, 64'h50); tick();
        set_f(4'd7, 64'h40, 64'h30); tick();
        n_checks++;
        if (F_predPC !== 64'h40) begin n_fail++; $display("FAIL jxx_pred got %h want %h", F_predPC, 64'h40); end
        idle(); M_icode = 4'd7; M_Cnd = 0; M_valA = 64'h13; set_f(4'd0, '0, 64'h14);
        @(negedge clk);
        n_checks++;
        if (f_pc !== 64'h13) begin n_fail++; $display("FAIL jxx_redirect got %h want %h", f_pc, 64'h13); end
        tick();
        idle(); set_f(4'd9, '0, 64'h99);
        @(negedge clk);
        n_checks++;
        if (f_ras_used !== 1'b0) begin n_fail++; $display("FAIL jxx_flushed got %b want 0", f_ras_used); end
        tick();
        n_checks++;
        if (F_predPC !== 64'h99) begin n_fail++; $display("FAIL jxx_ret_fallthru got %h want %h", F_predPC, 64'h99); end
    endtask

    task automatic test_call_ret();
        flush_ras();
        set_f(4'd8, 64'h100, 64'h20); tick();
        n_checks++;
        if (F_predPC !== 64'h100) begin n_fail++; $display("FAIL call_target got %h want %h", F_predPC, 64'h100); end
        set_f(4'd9, '0, 64'h101);
        @(negedge clk);
        n_checks++;
        if (f_ras_used !== RAS_ON) begin n_fail++; $display("FAIL ret_used got %b want %b", f_ras_used, RAS_ON); end
        n_checks++;
        if (f_ras_pred !== (RAS_ON ? 64'h20 : 64'h0)) begin n_fail++; $display("FAIL ret_pred got %h want %h", f_ras_pred, RAS_ON ? 64'h20 : 64'h0); end
        tick();
        n_checks++;
        if (F_predPC !== (RAS_ON ? 64'h20 : 64'h101)) begin n_fail++; $display("FAIL ret_predpc got %h want %h", F_predPC, RAS_ON ? 64'h20 : 64'h101); end
        idle(); W_icode = 4'd9; W_valM = 64'h20; W_ras_used = 1; W_ras_pred = 64'h20;
        @(negedge clk);
        n_checks++;
        if (f_pc !== 64'h20) begin n_fail++; $display("FAIL ret_correct_fpc got %h want %h", f_pc, 64'h20); end
        tick();
    endtask

    task automatic test_ret_mispredict();
        flush_ras();
        set_f(4'd8, 64'h100, 64'h20); tick();
        set_f(4'd9, '0, 64'h101); tick();
        idle(); W_icode = 4'd9; W_valM = 64'h28; W_ras_used = 1; W_ras_pred = 64'h20;
        set_f(4'd8, 64'h200, 64'h77);
        @(negedge clk);
        n_checks++;
        if (f_pc !== 64'h28) begin n_fail++; $display("FAIL ret_redirect got %h want %h", f_pc, 64'h28); end
        tick();
        idle(); set_f(4'd9, '0, 64'h5);
        @(negedge clk);
        n_checks++;
        if (f_ras_pred !== (RAS_ON ? 64'h77 : 64'h0)) begin n_fail++; $display("FAIL ret_flush_push got %h want %h", f_ras_pred, RAS_ON ? 64'h77 : 64'h0); end
        tick();
        set_f(4'd9, '0, 64'h6);
        @(negedge clk);
        n_checks++;
        if (f_ras_used !== 1'b0) begin n_fail++; $display("FAIL ret_flush_empty got %b want 0", f_ras_used); end
        tick();
    endtask

    task automatic test_ras_overflow();
        logic [AW-1:0] want;
        flush_ras();
        for (int k = 1; k <= 5; k++) begin
            set_f(4'd8, 64'h200, AW'(k * 16)); tick();
        end
        for (int k = 0; k < 5; k++) begin
            set_f(4'd9, '0, AW'(768 + k));
            @(negedge clk);
            want = (RAS_ON && k < 4) ? AW'(80 - 16 * k) : 64'h0;
            n_checks++;
            if (f_ras_pred !== want || f_ras_used !== (RAS_ON && k < 4)) begin
                n_fail++; $display("FAIL overflow_ret%0d got used=%b pred=%h want pred=%h", k, f_ras_used, f_ras_pred, want);
            end
            tick();
            want = (RAS_ON && k < 4) ? AW'(80 - 16 * k) : AW'(768 + k);
            n_checks++;
            if (F_predPC !== want) begin n_fail++; $display("FAIL overflow_pred%0d got %h want %h", k, F_predPC, want); end
        end
    endtask

    task automatic test_priority_stall();
        logic [AW-1:0] held;
        idle(); M_icode = 4'd7; M_valA = 64'h13; W_icode = 4'd9; W_valM = 64'h66;
        @(negedge clk);
        n_checks++;
        if (f_pc !== 64'h13) begin n_fail++; $display("FAIL priority_m_over_w got %h want %h", f_pc, 64'h13); end
        tick();
        idle(); set_f(4'd8, 64'h300, 64'hAA); tick();
        held = 64'h300;
        F_stall = 1; set_f(4'd8, 64'hCC, 64'hBB);
        tick(); tick();
        n_checks++;
        if (F_predPC !== held) begin n_fail++; $display("FAIL stall_hold got %h want %h", F_predPC, held); end
        F_stall = 0; set_f(4'd9, '0, 64'h1);
        @(negedge clk);
        n_checks++;
        if (f_ras_pred !== (RAS_ON ? 64'hAA : 64'h0)) begin n_fail++; $display("FAIL stall_ras_hold got %h want %h", f_ras_pred, RAS_ON ? 64'hAA : 64'h0); end
        tick();
    endtask

    task automatic test_async_reset();
        idle(); set_f(4'd8, 64'h400, 64'h44); tick();
        F_stall = 1; set_f(4'd9, '0, 64'h3);
        #2 rst_n = 1'b0;
        #1;
        exp_pred = '0; stk.delete();
        n_checks++;
        if (F_predPC !== 64'h0 || f_ras_used !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got pred=%h used=%b want pred=0 used=0", F_predPC, f_ras_used);
        end
        @(negedge clk);
        rst_n = 1'b1; idle();
        tick();
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            f_icode = (sel < 3) ? 4'd7 : (sel < 5) ? 4'd8 : (sel < 7) ? 4'd9 : 4'($urandom_range(0, 15));
            f_valC = {$urandom, $urandom};
            f_valP = AW'($urandom_range(0, 255)) << 2;
            M_icode = ($urandom_range(0, 5) == 0) ? 4'd7 : 4'($urandom_range(0, 6));
            M_Cnd = 1'($urandom_range(0, 1));
            M_valA = {$urandom, $urandom};
            W_icode = ($urandom_range(0, 4) == 0) ? 4'd9 : 4'd0;
            W_valM = AW'($urandom_range(0, 15));
            W_ras_used = 1'($urandom_range(0, 1));
            W_ras_pred = ($urandom_range(0, 1) == 1) ? W_valM : AW'($urandom_range(0, 15));
            F_stall = ($urandom_range(0, 4) == 0);
            model_eval();
            @(negedge clk);
            n_checks++;
            if (f_pc !== e_fpc || F_predPC !== exp_pred || f_ras_used !== e_used || f_ras_pred !== e_rpred) begin
                n_fail++;
                $display("FAIL random%0d got pc=%h pred=%h used=%b rpred=%h want pc=%h pred=%h used=%b rpred=%h",
                         n, f_pc, F_predPC, f_ras_used, f_ras_pred, e_fpc, exp_pred, e_used, e_rpred);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_jxx_mispredict();
        test_call_ret();
        test_ret_mispredict();
        test_ras_overflow();
        test_priority_stall();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter ADDR_W, default 64: width of every PC/address signal.
REQ-002 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, 2..16.
REQ-003 Parameter RESET_PC, default 0: fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 F_stall  input  1  high: hold F_predPC and all RAS state.
REQ-007 f_icode  input  4  icode of the instruction fetched at f_pc this cycle.
REQ-008 f_valC  input  ADDR_W  constant/destination field of the fetched instruction.
REQ-009 f_valP  input  ADDR_W  sequential next address of the fetched instruction.
REQ-010 M_icode  input  4  icode in memory stage.
REQ-011 M_Cnd  input  1  branch condition in memory stage.
REQ-012 M_valA  input  ADDR_W  fall-through address of a jXX in memory stage.
REQ-013 W_icode  input  4  icode in write-back stage.
REQ-014 W_valM  input  ADDR_W  actual return address of a ret in write-back.
REQ-015 W_ras_used  input  1  the W-stage ret was predicted from the RAS.
REQ-016 W_ras_pred  input  ADDR_W  target the RAS predicted for that ret.
REQ-017 f_pc  output  ADDR_W  address to fetch this cycle (combinational).
REQ-018 F_predPC  output  ADDR_W  registered predicted next PC.
REQ-019 f_ras_used  output  1  current ret is being predicted from the RAS; carried down the pipe.
REQ-020 f_ras_pred  output  ADDR_W  RAS-predicted target; carried down the pipe.

Function
REQ-021 f_pc priority: M_icode==7 and !M_Cnd -> M_valA; else W_icode==9 and ret_redirect -> W_valM; else F_predPC.
REQ-022 ret_redirect is true when W_icode==9, except when W_ras_used==1 and W_valM==W_ras_pred.
REQ-023 "redirect" means either of the first two REQ-021 cases is selected.
REQ-024 Next-PC prediction: f_icode 7 or 8 -> f_valC; f_icode 9 with RAS non-empty -> RAS top; otherwise -> f_valP.
REQ-025 When F_stall==0, F_predPC loads the REQ-024 prediction at the clock edge; one-cycle latency.
REQ-026 When F_stall==1, F_predPC, RAS entries, pointer and count are held unchanged.
REQ-027 RAS is circular with count 0..RAS_DEPTH.
REQ-028 On f_icode==8 with F_stall==0, the RAS pushes f_valP.
REQ-029 When count==RAS_DEPTH, a push overwrites the oldest entry and count stays saturated.
REQ-030 On f_icode==9 with F_stall==0 and count>0, the RAS pops; pointer wraps modulo RAS_DEPTH.
REQ-031 A ret with count==0 performs no pop and drives f_ras_used=0.
REQ-032 f_ras_used=1 and f_ras_pred=top when f_icode==9 and count>0; otherwise f_ras_used=0 and f_ras_pred=0.
REQ-033 On a redirect cycle with F_stall==0, the RAS is flushed to count 0 first.
REQ-034 The push or pop of the instruction fetched in that redirect cycle then applies to the empty stack (a call leaves count=1).
REQ-035 At most one push or pop per cycle; all ADDR_W arithmetic is unsigned, with no carry out.

Reset
REQ-036 While rst_n==0: F_predPC=RESET_PC, RAS count=0, pointer=0, all entries cleared.
REQ-037 Reset asserted mid-operation takes effect immediately regardless of clk or F_stall.
REQ-038 Combinational outputs then follow REQ-021/REQ-032 with the reset state.

Configuration
REQ-039 Macro FETCH_RAS_EN defined: the RAS and its behaviour (REQ-024 ret case, REQ-027..REQ-034) are compiled in.
REQ-040 FETCH_RAS_EN undefined: no RAS storage.
REQ-041 FETCH_RAS_EN undefined: ret predicts f_valP.
REQ-042 FETCH_RAS_EN undefined: f_ras_used=0 and f_ras_pred=0 constantly.
REQ-043 FETCH_RAS_EN undefined: every W-stage ret redirects.

Verification
REQ-044 Reset release, f_icode=0, f_valP=0x1 -> f_pc=0 at release; F_predPC=0x1 after one edge.
REQ-045 jXX valC=0x40 predicted; later M_icode=7, M_Cnd=0, M_valA=0x13 -> f_pc=0x13 that cycle; RAS count 0 afterwards.
REQ-046 call valP=0x20 then ret (FETCH_RAS_EN) -> f_ras_used=1, f_ras_pred=0x20, F_predPC=0x20.
REQ-046 (cont.) Then W_icode=9, W_valM=0x20, W_ras_used=1, W_ras_pred=0x20 -> no redirect, f_pc=F_predPC.
REQ-047 Same sequence with W_valM=0x28 -> f_pc=0x28 that cycle, RAS flushed; without FETCH_RAS_EN any W ret selects W_valM.
REQ-048 RAS_DEPTH=4: 5 calls with valP 0x10..0x50, then 5 rets -> predictions 0x50,0x40,0x30,0x20.
REQ-048 (cont.) 5th ret: f_ras_used=0, predicts f_valP.
REQ-049 M mispredict and W ret in the same cycle -> f_pc=M_valA.
REQ-049 (cont.) F_stall=1 with a call fetched -> F_predPC and RAS count unchanged.
